param_bus_master: RTL and testbench
===================================

PARAM_BUS_MASTER -- requirements
Module: param_bus_master

Interface
REQ-001 Parameter DATA_W, default 8, width of write and read data.
REQ-002 Parameter ADDR_W, default 8, width of the address.
REQ-003 Parameter DEPTH, default 4, command queue entries; power of 2, >=2.
REQ-004 Parameter TIMEOUT_CYC, default 16, handshake timeout in cycles (used only with BUS_TIMEOUT_EN).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wr_start  in  1  one-cycle pulse; queue a write of wr_data to wr_addr.
REQ-008 rd_start  in  1  one-cycle pulse; queue a read from rd_addr.
REQ-009 wr_addr, rd_addr  in  ADDR_W  request addresses, sampled with the start pulse.
REQ-010 wr_data  in  DATA_W  write data, sampled with wr_start.
REQ-011 rd_data  out  DATA_W  last completed read data; held until the next successful read.
REQ-012 rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-013 q_full  out  1  high when fewer than 2 queue entries are free.
REQ-014 q_ovf  out  1  one-cycle pulse when a start pulse is dropped.
REQ-015 m_req  out  1  bus request to the slave.
REQ-016 m_r0_w1  out  1  bus direction: 0 read, 1 write; valid while m_req is high.
REQ-017 m_addr  out  ADDR_W  bus address; valid while m_req is high.
REQ-018 m_wr_data  out  DATA_W  bus write data; valid from m_req rise until s_data_ack.
REQ-019 m_rd_data  in  DATA_W  slave read data; valid in the cycle s_data_ack is high.
REQ-020 s_ack  in  1  slave accepts the request.
REQ-021 s_data_ack  in  1  slave has consumed write data or is driving read data.
REQ-022 m_done  out  1  one-cycle pulse at the end of every bus transaction.
REQ-023 m_err  out  1  one-cycle pulse, coincident with m_done, on a timed-out transaction.

Function
REQ-024 Each start pulse shall write one command entry {dir, addr, data} into a FIFO of DEPTH entries at the sampling edge.
REQ-025 If wr_start and rd_start arrive in the same cycle, the write shall be queued first and the read second.
REQ-026 While q_full is high, every start pulse shall be dropped and q_ovf pulsed; the queue is never partially written.
REQ-027 FSM states: IDLE, REQ, DATA, DONE.
REQ-028 IDLE with a non-empty queue: pop the head and enter REQ at the next edge, driving m_req=1, m_r0_w1, m_addr, and m_wr_data (0 for reads).
REQ-029 REQ: on s_ack sampled high, deassert m_req at that edge and enter DATA.
REQ-030 DATA: on s_data_ack sampled high, capture m_rd_data into rd_data for reads, and enter DONE.
REQ-031 DONE: m_done=1 (and rd_valid=1 for a successful read) for exactly one cycle, then return to IDLE.
REQ-032 Latency: with an empty queue in IDLE, a start pulse at edge N gives m_req high after edge N+1.
REQ-033 Transactions are back-to-back: one idle cycle (IDLE) between DONE and the next m_req.
REQ-034 s_ack outside REQ and s_data_ack outside DATA shall be ignored.
REQ-035 A push and a pop in the same cycle shall both occur; occupancy is unchanged.
REQ-036 Pointers shall wrap modulo DEPTH.

Reset
REQ-037 On rst: FSM to IDLE, queue emptied, and rd_data, m_addr, m_wr_data set to 0.
REQ-038 On rst: m_req, m_r0_w1, m_done, m_err, rd_valid, q_ovf set to 0; q_full set to 0.
REQ-039 Reset mid-transaction shall abandon the transaction and all queued commands, with no m_done.

Configuration
REQ-040 Macro BUS_TIMEOUT_EN defined: a cycle counter runs in REQ and DATA and clears on each state entry.
REQ-041 With BUS_TIMEOUT_EN, reaching TIMEOUT_CYC cycles shall deassert m_req, enter DONE, and pulse m_err.
REQ-042 With BUS_TIMEOUT_EN, a timed-out read shall leave rd_data unchanged and give no rd_valid.
REQ-043 Macro BUS_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely; m_err is tied 0.

Verification
REQ-044 Write 0xA5 to 0x3C, slave acks after 2 cycles -> m_req, m_r0_w1=1, m_addr=0x3C, m_wr_data=0xA5; one m_done.
REQ-045 Read from 0x3C, slave returns 0xA5 -> rd_data=0xA5, rd_valid and m_done each pulse once.
REQ-046 wr_start and rd_start in the same cycle -> write transaction first, then read; two m_done pulses.
REQ-047 Six starts with a stalled slave, DEPTH=4 -> q_full after 3 entries; later starts pulse q_ovf; queued commands complete in order.
REQ-048 BUS_TIMEOUT_EN, slave never acks -> m_done and m_err together at cycle 16 of REQ; the next command proceeds.
REQ-049 rst asserted during DATA -> all outputs 0 immediately; no m_done; queue empty.

Source files
------------

// File: rtl/param_bus_master.sv
// rtl/param_bus_master.sv - queued request/ack bus master with command FIFO
// Optional handshake timeout enabled by defining BUS_TIMEOUT_EN.
module param_bus_master #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_start,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              q_full,
    output logic              q_ovf,
    output logic              m_req,
    output logic              m_r0_w1,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              s_ack,
    input  logic              s_data_ack,
    output logic              m_done,
    output logic              m_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;
    state_t state_q, state_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, rd_slot;
    logic [CNT_W-1:0]  cnt_q, cnt_d, n_push;
    logic              accept, pop, ovf_q, ovf_d;
    logic              m_req_q, m_req_d, dir_q, dir_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic              timeout;

    // Full leaves room for a simultaneous write+read pair, so a pair is never split.
    assign q_full  = cnt_q >= CNT_W'(DEPTH - 1);
    assign accept  = (wr_start | rd_start) & ~q_full;
    assign ovf_d   = (wr_start | rd_start) & q_full;
    assign pop     = (state_q == IDLE) && (cnt_q != '0);
    assign rd_slot = wptr_q + PTR_W'(wr_start);

    always_comb begin
        n_push = '0;
        if (accept) n_push = CNT_W'(wr_start) + CNT_W'(rd_start);
        wptr_d = wptr_q + n_push[PTR_W-1:0];
        rptr_d = rptr_q + PTR_W'(pop);
        cnt_d  = cnt_q + n_push - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (accept && wr_start) mem_q[wptr_q]  <= {1'b1, wr_addr, wr_data};
        if (accept && rd_start) mem_q[rd_slot] <= {1'b0, rd_addr, {DATA_W{1'b0}}};
    end

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign timeout = (tcnt_q == TW'(TIMEOUT_CYC - 1));
    assign tcnt_d  = (state_d != state_q) ? '0 : tcnt_q + TW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tcnt_q <= '0;
        else     tcnt_q <= tcnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (pop) begin
                    {dir_d, addr_d, wdata_d} = mem_q[rptr_q];
                    m_req_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (s_ack) begin
                    m_req_d = 1'b0;
                    state_d = DATA;
                end else if (timeout) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DATA: begin
                if (s_data_ack) begin
                    if (!dir_q) rd_data_d = m_rd_data;
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            m_req_q   <= 1'b0;
            dir_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            m_req_q   <= m_req_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

    assign m_req     = m_req_q;
    assign m_r0_w1   = dir_q;
    assign m_addr    = addr_q;
    assign m_wr_data = wdata_q;
    assign rd_data   = rd_data_q;
    assign q_ovf     = ovf_q;
    assign m_done    = (state_q == DONE);
    assign rd_valid  = (state_q == DONE) && !dir_q && !err_q;
`ifdef BUS_TIMEOUT_EN
    assign m_err     = (state_q == DONE) && err_q;
`else
    assign m_err     = 1'b0;
`endif

endmodule

// File: tb/tb_param_bus_master.sv
// tb/tb_param_bus_master.sv - directed and randomized checks of param_bus_master against a queue model
// Timeout checks are compiled in when BUS_TIMEOUT_EN is defined.
module tb_param_bus_master;
    localparam int DEPTH       = 4;
    localparam int TIMEOUT_CYC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_start, rd_start, s_ack, s_data_ack;
    logic [7:0] wr_addr, rd_addr, wr_data, m_rd_data;
    logic [7:0] rd_data, m_addr, m_wr_data;
    logic       rd_valid, q_full, q_ovf, m_req, m_r0_w1, m_done, m_err;

    param_bus_master #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .wr_start(wr_start), .rd_start(rd_start),
        .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .q_full(q_full), .q_ovf(q_ovf),
        .m_req(m_req), .m_r0_w1(m_r0_w1), .m_addr(m_addr), .m_wr_data(m_wr_data),
        .m_rd_data(m_rd_data), .s_ack(s_ack), .s_data_ack(s_data_ack),
        .m_done(m_done), .m_err(m_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         dir;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    cmd_t       exp_q[$];
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit w, input bit r, input logic [7:0] wa, input logic [7:0] wd,
                         input logic [7:0] ra);
        wr_start = w; rd_start = r; wr_addr = wa; wr_data = wd; rd_addr = ra;
        if (w) exp_q.push_back('{1'b1, wa, wd});
        if (r) exp_q.push_back('{1'b0, ra, 8'h00});
        @(negedge clk);
        wr_start = 1'b0; rd_start = 1'b0;
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (!m_req && n < limit) begin @(negedge clk); n++; end
        check("req_seen", m_req, 1);
    endtask

    // Plays the slave for the oldest outstanding command and checks the master against it.
    task automatic do_txn(input int ack_dly, input int dack_dly);
        cmd_t       c;
        logic [7:0] rv;
        if (exp_q.size() == 0) begin
            check("txn_expected", 0, 1);
            return;
        end
        c = exp_q.pop_front();
        wait_req(60);
        check("dir", m_r0_w1, c.dir);
        check("addr", m_addr, c.addr);
        check("wdata", m_wr_data, c.data);
        repeat (ack_dly) begin
            s_data_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("req_hold", m_req, 1);
        end
        s_data_ack = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        check("req_drop", m_req, 0);
        repeat (dack_dly) begin
            s_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("no_early_done", m_done, 0);
        end
        s_ack = 1'b0;
        rv = 8'($urandom);
        if (c.dir) ref_mem[c.addr] = c.data;
        else begin
            rv = ref_mem[c.addr];
            exp_rd = rv;
        end
        m_rd_data = rv; s_data_ack = 1'b1;
        @(negedge clk);
        s_data_ack = 1'b0; m_rd_data = 8'($urandom);
        check("done", m_done, 1);
        check("rd_valid", rd_valid, !c.dir);
        check("err", m_err, 0);
        check("rd_data", rd_data, exp_rd);
        @(negedge clk);
        check("done_one_cycle", m_done, 0);
        check("rd_valid_one_cycle", rd_valid, 0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) do_txn($urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {m_req, m_r0_w1, rd_valid, m_done, m_err, q_full, q_ovf}, 0);
        check({tag, "_buses"}, {m_addr, m_wr_data, rd_data}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   occ;
        bit   busy, full, dir;
        logic [7:0] a, d;
        int   n;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        exp_rd = 8'h00;
        rst = 1'b1; wr_start = 0; rd_start = 0; s_ack = 0; s_data_ack = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0; m_rd_data = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Write 0xA5 to 0x3C with start-to-request latency check.
        issue(1, 0, 8'h3C, 8'hA5, 8'h00);
        check("latency_edge_n", m_req, 0);
        @(negedge clk);
        check("latency_edge_n1", m_req, 1);
        do_txn(2, 1);

        // Read back 0x3C.
        issue(0, 1, 8'h00, 8'h00, 8'h3C);
        do_txn(1, 2);
        check("readback_a5", rd_data, 8'hA5);

        // Simultaneous write and read: write goes first.
        issue(1, 1, 8'h10, 8'h5A, 8'h10);
        do_txn(0, 0);
        do_txn(0, 0);
        check("same_cycle_rd", rd_data, 8'h5A);

        // Six back-to-back starts against a stalled slave.
        occ = 0; busy = 0;
        for (int i = 0; i < 6; i++) begin
            dir = 1'($urandom_range(0, 1));
            a = 8'($urandom); d = 8'($urandom);
            wr_start = dir; rd_start = !dir;
            wr_addr = a; wr_data = d; rd_addr = a;
            full = (occ >= DEPTH - 1);
            if (!full) exp_q.push_back('{dir, a, dir ? d : 8'h00});
            if (!busy && occ > 0) begin
                occ--;
                busy = 1;
            end
            if (!full) occ++;
            @(negedge clk);
            wr_start = 0; rd_start = 0;
            check("stall_q_full", q_full, occ >= DEPTH - 1);
            check("stall_q_ovf", q_ovf, full);
        end
        @(negedge clk);
        check("ovf_cleared", q_ovf, 0);
        check("stall_req_held", m_req, 1);
        drain();
        repeat (4) begin
            @(negedge clk);
            check("idle_after_drain", m_req, 0);
        end
        check("q_empty_after_drain", q_full, 0);

        // Randomized mixes of starts, each drained through the model.
        for (int i = 0; i < 15; i++) begin
            n = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 3));
            issue(n != 1, n != 0, a, 8'($urandom), 8'($urandom_range(0, 3)));
            drain();
        end

        // Reset in the data phase with more commands queued.
        issue(1, 0, 8'h05, 8'h77, 8'h00);
        wait_req(10);
        s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        issue(1, 1, 8'h06, 8'h11, 8'h06);
        rst = 1'b1;
        #1;
        check_all_zero("mid_data_reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_rd = 8'h00;
        repeat (6) begin
            @(negedge clk);
            check("abandoned_quiet", {m_req, m_done}, 0);
        end
        issue(0, 1, 8'h00, 8'h00, 8'h3C);
        do_txn(0, 0);

`ifdef BUS_TIMEOUT_EN
        // Slave never acks the write; the queued read must still complete.
        issue(1, 1, 8'h20, 8'hC3, 8'h20);
        void'(exp_q.pop_front());
        wait_req(10);
        n = 0;
        while (m_req && n < 40) begin @(negedge clk); n++; end
        check("timeout_len", n, TIMEOUT_CYC);
        check("timeout_done", m_done, 1);
        check("timeout_err", m_err, 1);
        check("timeout_no_rd_valid", rd_valid, 0);
        @(negedge clk);
        check("timeout_err_pulse", m_err, 0);
        do_txn(1, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
